alu_seq_exec: RTL and testbench

- Parametrised ALU control and execute unit for the multi-cycle datapath.
- Decodes AluOp/Funct internally and executes on WIDTH-bit operands; the result is registered.
- Single-cycle ops finish in 1 cycle. Shifts run iteratively, one bit per cycle for shamt cycles.
- Uses a start/busy/done handshake so the main control FSM can stall on multi-cycle ops.

---
 rtl/alu_seq_exec.sv | 199 +++++++++++++++++++
 tb/tb_alu_seq_exec.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: ALU control and execute unit for the multi-cycle datapath.
//
// Decodes alu_op/funct, executes on WIDTH-bit operands and registers the
// result. Single-cycle ops complete one cycle after start. sll/srl shift one
// bit per cycle for shamt cycles. A start/busy/done handshake lets the main
// control FSM stall on multi-cycle ops.
//
// Optional feature: define ALU_SEQ_MUL_EN to enable funct 011000 (mul), an
// unsigned shift-add multiply taking WIDTH RUN cycles. When undefined, that
// funct decodes as illegal.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset
//   start   in   request, accepted only when busy=0
//   alu_op  in   00 add, 01 sub, 10 use funct, 11 illegal
//   funct   in   function field (alu_op=10)
//   shamt   in   shift amount for sll/srl
//   src_a   in   operand A
//   src_b   in   operand B (shift source)
//   busy    out  high while an iterative op runs
//   done    out  one-cycle pulse when result is valid
//   result  out  registered result, held until the next op completes
//   zero    out  registered (result == 0)
//   illegal out  registered, set when the completed op was undecodable
module alu_seq_exec #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal
);

    // One extra bit so the counter can hold WIDTH for the multiply.
    localparam int unsigned CntW = SHAMT_W + 1;

    localparam logic [FUNCT_W-1:0] FnAdd = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] FnSub = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] FnAnd = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] FnOr  = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] FnNor = FUNCT_W'(6'b100111);
    localparam logic [FUNCT_W-1:0] FnSlt = FUNCT_W'(6'b101010);
    localparam logic [FUNCT_W-1:0] FnSll = FUNCT_W'(6'b000000);
    localparam logic [FUNCT_W-1:0] FnSrl = FUNCT_W'(6'b000010);
`ifdef ALU_SEQ_MUL_EN
    localparam logic [FUNCT_W-1:0] FnMul = FUNCT_W'(6'b011000);
`endif

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    typedef enum logic [2:0] {KindAlu, KindSll, KindSrl, KindMul, KindIll} kind_e;

    state_e             state_q;
    logic [WIDTH-1:0]   sh_q;
    logic               sh_dir_q;  // 1 = shift right
    logic [CntW-1:0]    cnt_q;

    kind_e              dec_kind;
    logic [WIDTH-1:0]   dec_res;
    logic [WIDTH-1:0]   run_res;
    logic               fin_en;
    logic [WIDTH-1:0]   fin_val;
    logic               fin_ill;

`ifdef ALU_SEQ_MUL_EN
    logic               is_mul_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   acc_next;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign run_res  = is_mul_q ? acc_next : (sh_dir_q ? (sh_q >> 1) : (sh_q << 1));
`else
    assign run_res  = sh_dir_q ? (sh_q >> 1) : (sh_q << 1);
`endif

    // Decode of the live inputs; only used on the accepting edge.
    always_comb begin
        dec_kind = KindIll;
        dec_res  = '0;
        unique case (alu_op)
            2'b00: begin dec_kind = KindAlu; dec_res = src_a + src_b; end
            2'b01: begin dec_kind = KindAlu; dec_res = src_a - src_b; end
            2'b10: begin
                case (funct)
                    FnAdd: begin dec_kind = KindAlu; dec_res = src_a + src_b; end
                    FnSub: begin dec_kind = KindAlu; dec_res = src_a - src_b; end
                    FnAnd: begin dec_kind = KindAlu; dec_res = src_a & src_b; end
                    FnOr:  begin dec_kind = KindAlu; dec_res = src_a | src_b; end
                    FnNor: begin dec_kind = KindAlu; dec_res = ~(src_a | src_b); end
                    FnSlt: begin
                        dec_kind = KindAlu;
                        dec_res  = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
                    end
                    FnSll: dec_kind = KindSll;
                    FnSrl: dec_kind = KindSrl;
`ifdef ALU_SEQ_MUL_EN
                    FnMul: dec_kind = KindMul;
`endif
                    default: dec_kind = KindIll;
                endcase
            end
            default: dec_kind = KindIll;
        endcase
    end

    // Completion: last RUN step, or a single-cycle op accepted this cycle.
    always_comb begin
        fin_en  = 1'b0;
        fin_val = dec_res;
        fin_ill = 1'b0;
        if (state_q == StRun) begin
            fin_en  = (cnt_q == CntW'(1));
            fin_val = run_res;
        end else if (start) begin
            case (dec_kind)
                KindSll, KindSrl: begin
                    fin_en  = (shamt == '0);
                    fin_val = src_b;
                end
                KindMul: fin_en = 1'b0;
                KindIll: begin
                    fin_en  = 1'b1;
                    fin_val = '0;
                    fin_ill = 1'b1;
                end
                default: fin_en = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            sh_q     <= '0;
            sh_dir_q <= 1'b0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            illegal  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            is_mul_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            done <= fin_en;
            if (fin_en) begin
                result  <= fin_val;
                zero    <= (fin_val == '0);
                illegal <= fin_ill;
                busy    <= 1'b0;
                state_q <= StDone;
            end else if (state_q == StRun) begin
                cnt_q <= cnt_q - CntW'(1);
                sh_q  <= run_res;
`ifdef ALU_SEQ_MUL_EN
                acc_q    <= acc_next;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
`endif
            end else if (start) begin
                // Only iterative ops reach here: shift with shamt>0, or mul.
                busy     <= 1'b1;
                state_q  <= StRun;
                sh_q     <= src_b;
                sh_dir_q <= (dec_kind == KindSrl);
                cnt_q    <= {1'b0, shamt};
`ifdef ALU_SEQ_MUL_EN
                is_mul_q <= (dec_kind == KindMul);
                acc_q    <= '0;
                mcand_q  <= src_a;
                mplier_q <= src_b;
                if (dec_kind == KindMul) begin
                    cnt_q <= CntW'(WIDTH);
                end
`endif
            end else begin
                state_q <= StIdle;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
module tb_alu_seq_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    alu_seq_exec #(
        .WIDTH  (32),
        .SHAMT_W(5),
        .FUNCT_W(6)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .alu_op (alu_op),
        .funct  (funct),
        .shamt  (shamt),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sa;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    // Start at a negedge, scramble inputs after acceptance, wait for done.
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        int busy_cnt;
        @(negedge clk);
        alu_op = v.op; funct = v.fn; shamt = v.sa; src_a = v.a; src_b = v.b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        alu_op = 2'b11; funct = 6'h3f; shamt = 5'd7; src_a = 32'hdeadbeef; src_b = 32'h12345678;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 200) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"},  32'(lat), 32'(v.lat));
        check({tag, "_busy"}, 32'(busy_cnt), 32'(v.lat - 1));
        check({tag, "_res"},  result, v.res);
        check({tag, "_zero"}, 32'(zero), 32'(v.z));
        check({tag, "_ill"},  32'(illegal), 32'(v.ill));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    // Start an iterative op, reset at T+10, expect reset values and no done.
    task automatic reset_abort(input logic [5:0] fn, input logic [4:0] sa,
                               input logic [31:0] a, input logic [31:0] b, input string tag);
        int dcnt;
        @(negedge clk);
        alu_op = 2'b10; funct = fn; shamt = sa; src_a = a; src_b = b; start = 1'b1;
        dcnt = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dcnt++;
        end
        check({tag, "_busy_pre"}, 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_res"},  result, 32'd0);
        check({tag, "_zero"}, 32'(zero), 32'd1);
        check({tag, "_ill"},  32'(illegal), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check({tag, "_no_done"}, 32'(dcnt), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{2'b00, 6'h00, 5'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1};
        vecs[1]  = '{2'b01, 6'h00, 5'd0, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1};
        vecs[2]  = '{2'b01, 6'h00, 5'd0, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1};
        vecs[3]  = '{2'b00, 6'h00, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1};
        vecs[4]  = '{2'b10, 6'b100000, 5'd0, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 1};
        vecs[5]  = '{2'b10, 6'b100010, 5'd0, 32'h30, 32'h10, 32'h20, 1'b0, 1'b0, 1};
        vecs[6]  = '{2'b10, 6'b100100, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000,
                     1'b0, 1'b0, 1};
        vecs[7]  = '{2'b10, 6'b100101, 5'd0, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0,
                     1'b0, 1'b0, 1};
        vecs[8]  = '{2'b10, 6'b100111, 5'd0, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd0, 1'b1, 1'b0, 1};
        vecs[9]  = '{2'b10, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1};
        vecs[10] = '{2'b10, 6'b101010, 5'd0, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1};
        vecs[11] = '{2'b10, 6'b101010, 5'd0, 32'h7FFFFFFF, 32'h80000000, 32'd0, 1'b1, 1'b0, 1};
        vecs[12] = '{2'b10, 6'b000000, 5'd4, 32'd0, 32'h0000000F, 32'h000000F0, 1'b0, 1'b0, 5};
        vecs[13] = '{2'b10, 6'b000010, 5'd0, 32'd0, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1};
        vecs[14] = '{2'b10, 6'b000010, 5'd31, 32'd0, 32'h80000000, 32'd1, 1'b0, 1'b0, 32};
        vecs[15] = '{2'b10, 6'b111111, 5'd0, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 1};
        vecs[16] = '{2'b11, 6'b100000, 5'd0, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 1};
`ifdef ALU_SEQ_MUL_EN
        vecs[17] = '{2'b10, 6'b011000, 5'd0, 32'h00010000, 32'h00010001, 32'h00010000,
                     1'b0, 1'b0, 33};
`else
        vecs[17] = '{2'b10, 6'b011000, 5'd0, 32'h00010000, 32'h00010001, 32'd0, 1'b1, 1'b1, 1};
`endif
        vecs[18] = '{2'b10, 6'b000000, 5'd31, 32'd0, 32'd3, 32'h80000000, 1'b0, 1'b0, 32};

        // Reset held with start high: nothing accepted.
        reset = 1'b1; start = 1'b1; alu_op = 2'b00; funct = 6'h00; shamt = 5'd0;
        src_a = 32'd1; src_b = 32'd1;
        repeat (4) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res",  result, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_ill",  32'(illegal), 32'd0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_after_done", 32'(done), 32'd0);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i], $sformatf("v%0d", i));
        end

        // Back-to-back: start accepted while in DONE, done stays high.
        run_op(vecs[0], "b2b_first");
        alu_op = 2'b00; src_a = 32'd10; src_b = 32'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_res",  result, 32'd30);
        @(negedge clk);
        check("b2b_drop", 32'(done), 32'd0);

        // Start during RUN is ignored.
        @(negedge clk);
        alu_op = 2'b10; funct = 6'b000000; shamt = 5'd4; src_b = 32'hF; start = 1'b1;
        @(negedge clk);                      // T+1
        start = 1'b0;
        check("ign_busy1", 32'(busy), 32'd1);
        @(negedge clk);                      // T+2
        alu_op = 2'b00; src_a = 32'd1; src_b = 32'd1; start = 1'b1;
        @(negedge clk);                      // T+3
        start = 1'b0;
        check("ign_busy3", 32'(busy), 32'd1);
        check("ign_done3", 32'(done), 32'd0);
        check("ign_res3",  result, 32'd30);
        @(negedge clk);                      // T+4
        check("ign_done4", 32'(done), 32'd0);
        @(negedge clk);                      // T+5
        check("ign_done5", 32'(done), 32'd1);
        check("ign_res5",  result, 32'h000000F0);
        @(negedge clk);                      // T+6
        check("ign_done6", 32'(done), 32'd0);
        check("ign_busy6", 32'(busy), 32'd0);

        // Reset in the middle of an iterative op.
        reset_abort(6'b000010, 5'd31, 32'd0, 32'h80000000, "abort_srl");
`ifdef ALU_SEQ_MUL_EN
        run_op(vecs[0], "pre_mul_abort");
        reset_abort(6'b011000, 5'd0, 32'h00010000, 32'h00010001, "abort_mul");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
